// File: rtl/map_write_arbiter.sv
// map_write_arbiter
//   Owns the ROWS x COLS card map feeding the card renderer and shares its
//   single write port between requester A (local game logic) and requester B
//   (interboard receiver). One position write per cycle, round-robin between
//   A and B when both ask. Also sequences a full-map clear sweep.
//
//   Optional feature macro: MAP_VBLANK_SYNC_EN
//     defined   -> writes and clear steps only while v_cnt >= BLANK_LINE
//     undefined -> writes and clear steps every cycle, v_cnt unused
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   v_cnt             VGA line counter (synchronous to clk)
//   req_x/pos_x/card_x  level write request, position row*COLS+col, card code
//   ack_x             one-cycle pulse, request consumed
//   clear_req         one-cycle pulse, clear whole map to 0
//   busy              high during the clear sweep
//   err               one-cycle pulse, consumed request was rejected
//   map_changed       one-cycle pulse after a write or a completed clear
//   map               map[p*6 +: 6] is the card code at position p
module map_write_arbiter #(
  parameter int ROWS       = 8,
  parameter int COLS       = 18,
  parameter int BLANK_LINE = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             v_cnt,
  input  logic                   req_a,
  input  logic [7:0]             pos_a,
  input  logic [5:0]             card_a,
  output logic                   ack_a,
  input  logic                   req_b,
  input  logic [7:0]             pos_b,
  input  logic [5:0]             card_b,
  output logic                   ack_b,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   err,
  output logic                   map_changed,
  output logic [ROWS*COLS*6-1:0] map
);

  localparam int         NPOS     = ROWS * COLS;
  localparam int         MAPW     = NPOS * 6;
  localparam int         IW       = $clog2(MAPW);
  localparam logic [8:0] NPOS_V   = 9'(NPOS);
  localparam logic [7:0] LAST_IDX = 8'(NPOS - 1);
  localparam logic [5:0] MAX_CARD = 6'd54;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t          r_state, w_next_state;
  logic [MAPW-1:0] r_map;
  logic [7:0]      r_idx;
  logic            r_last_b;   // 1: B was granted last, so A wins next contention
  logic            r_ack_a, r_ack_b, r_err, r_chg;

  logic            w_win;
  logic            w_gnt_a, w_gnt_b, w_gnt, w_bad;
  logic            w_wr_en, w_clr_done;
  logic [7:0]      w_wr_pos;
  logic [5:0]      w_wr_card;
  logic [IW-1:0]   w_bit_base;

`ifdef MAP_VBLANK_SYNC_EN
  assign w_win = (v_cnt >= 10'(BLANK_LINE));
`else
  logic w_unused_vcnt;
  assign w_unused_vcnt = ^v_cnt;
  assign w_win = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    w_bad        = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_pos     = '0;
    w_wr_card    = '0;
    w_clr_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // clear takes priority; pending requests simply keep waiting
        if (clear_req) begin
          w_next_state = S_CLEAR;
        end else if (w_win && (req_a || req_b)) begin
          if (req_a && req_b) begin
            w_gnt_a = r_last_b;
            w_gnt_b = ~r_last_b;
          end else begin
            w_gnt_a = req_a;
            w_gnt_b = req_b;
          end
          w_wr_pos  = w_gnt_a ? pos_a  : pos_b;
          w_wr_card = w_gnt_a ? card_a : card_b;
          // card 0 is refused here: only the sweep may write empty codes
          w_bad     = ({1'b0, w_wr_pos} >= NPOS_V) || (w_wr_card == 6'd0) ||
                      (w_wr_card > MAX_CARD);
          w_wr_en   = ~w_bad;
        end
      end
      S_CLEAR: begin
        if (w_win) begin
          w_wr_en  = 1'b1;
          w_wr_pos = r_idx;
          if (r_idx == LAST_IDX) begin
            w_clr_done   = 1'b1;
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_gnt      = w_gnt_a | w_gnt_b;
  assign w_bit_base = IW'(w_wr_pos) * IW'(6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_map    <= '0;
      r_idx    <= '0;
      r_last_b <= 1'b1;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_err    <= 1'b0;
      r_chg    <= 1'b0;
    end else begin
      r_ack_a <= w_gnt_a;
      r_ack_b <= w_gnt_b;
      r_err   <= w_bad;
      r_chg   <= (w_gnt && !w_bad) || w_clr_done;
      if (w_gnt) r_last_b <= w_gnt_b;
      if (r_state == S_CLEAR && w_win)
        r_idx <= w_clr_done ? 8'd0 : r_idx + 8'd1;
      if (w_wr_en) r_map[w_bit_base +: 6] <= w_wr_card;
    end
  end

  assign ack_a       = r_ack_a;
  assign ack_b       = r_ack_b;
  assign err         = r_err;
  assign map_changed = r_chg;
  assign busy        = (r_state == S_CLEAR);
  assign map         = r_map;

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter: reset, single write, contention,
// rejects and boundaries, full clear with pending request, reset mid-clear,
// and v_cnt window behaviour for whichever build is compiled.
module tb_map_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [9:0]   v_cnt;
  logic         req_a, req_b, clear_req;
  logic [7:0]   pos_a, pos_b;
  logic [5:0]   card_a, card_b;
  logic         ack_a, ack_b, busy, err, map_changed;
  logic [863:0] map;

  logic [863:0] exp_map;
  int           errors = 0;
  int           checks = 0;
  int           cnt;

  map_write_arbiter dut (
    .clk(clk), .rst(rst), .v_cnt(v_cnt),
    .req_a(req_a), .pos_a(pos_a), .card_a(card_a), .ack_a(ack_a),
    .req_b(req_b), .pos_b(pos_b), .card_b(card_b), .ack_b(ack_b),
    .clear_req(clear_req), .busy(busy), .err(err),
    .map_changed(map_changed), .map(map)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [863:0] obs, input logic [863:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int p, input int c);
    exp_map[p*6 +: 6] = 6'(c);
  endtask

  task automatic chk_pulses(input string tag, input logic a, input logic b,
                            input logic e, input logic c);
    chk({tag, ".ack_a"}, 864'(ack_a), 864'(a));
    chk({tag, ".ack_b"}, 864'(ack_b), 864'(b));
    chk({tag, ".err"},   864'(err),   864'(e));
    chk({tag, ".chg"},   864'(map_changed), 864'(c));
  endtask

  initial begin
    rst = 1'b1; v_cnt = 10'd480;
    req_a = 0; req_b = 0; clear_req = 0;
    pos_a = 0; pos_b = 0; card_a = 0; card_b = 0;
    exp_map = '0;

    // reset state
    repeat (2) step();
    chk_pulses("reset", 0, 0, 0, 0);
    chk("reset.busy", 864'(busy), 864'(0));
    chk("reset.map", map, '0);
    rst = 1'b0;
    step();

    // single request: pos 5 card 12
    req_a = 1; pos_a = 8'd5; card_a = 6'd12;
    step();
    req_a = 0;
    set_exp(5, 12);
    chk_pulses("single", 1, 0, 0, 1);
    chk("single.map5", 864'(map[30 +: 6]), 864'(12));
    chk("single.map", map, exp_map);
    step();
    chk_pulses("single.after", 0, 0, 0, 0);

    // contention right after reset: A, B, A, B
    rst = 1'b1; step(); rst = 1'b0; exp_map = '0;
    req_a = 1; pos_a = 8'd10; card_a = 6'd1;
    req_b = 1; pos_b = 8'd20; card_b = 6'd2;
    step(); chk_pulses("cont1", 1, 0, 0, 1);
    step(); chk_pulses("cont2", 0, 1, 0, 1);
    step(); chk_pulses("cont3", 1, 0, 0, 1);
    step(); chk_pulses("cont4", 0, 1, 0, 1);
    req_a = 0; req_b = 0;
    set_exp(10, 1); set_exp(20, 2);
    chk("cont.map", map, exp_map);

    // rejects, back-to-back on B
    req_b = 1; pos_b = 8'd144; card_b = 6'd5;
    step(); chk_pulses("rej.pos144", 0, 1, 1, 0);
    pos_b = 8'd3; card_b = 6'd0;
    step(); chk_pulses("rej.card0", 0, 1, 1, 0);
    pos_b = 8'd0; card_b = 6'd55;
    step(); chk_pulses("rej.card55", 0, 1, 1, 0);
    pos_b = 8'd255; card_b = 6'd7;
    step(); chk_pulses("rej.pos255", 0, 1, 1, 0);
    chk("rej.map", map, exp_map);
    // boundaries that must be accepted
    pos_b = 8'd143; card_b = 6'd54;
    step(); chk_pulses("ok.143_54", 0, 1, 0, 1);
    req_b = 0;
    set_exp(143, 54);
    chk("ok.map", map, exp_map);

    // fill the whole map through A, one write per cycle
    for (int p = 0; p < 144; p++) begin
      req_a = 1; pos_a = 8'(p); card_a = 6'((p % 54) + 1);
      step();
      set_exp(p, (p % 54) + 1);
      chk("fill.ack", 864'({ack_a, map_changed}), 864'(2'b11));
    end
    chk("fill.map", map, exp_map);

    // clear with A pending; a second clear_req mid-sweep is ignored
    pos_a = 8'd7; card_a = 6'd9; clear_req = 1;
    step();
    clear_req = 0;
    chk_pulses("clr.start", 0, 0, 0, 0);
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      if (cnt == 50) clear_req = 1;
      if (ack_a) chk("clr.noack", 864'(ack_a), 864'(0));
      step();
      clear_req = 0;
    end
    chk("clr.busy_cycles", 864'(cnt), 864'(144));
    chk_pulses("clr.done", 0, 0, 0, 1);
    exp_map = '0;
    chk("clr.map", map, exp_map);
    step();
    req_a = 0;
    set_exp(7, 9);
    chk_pulses("clr.pending", 1, 0, 0, 1);
    chk("clr.pending.map", map, exp_map);

    // reset in the middle of a sweep
    req_b = 1; pos_b = 8'd100; card_b = 6'd33;
    step(); req_b = 0;
    set_exp(100, 33);
    chk("mid.pre", map, exp_map);
    clear_req = 1; step(); clear_req = 0;
    repeat (70) step();
    chk("mid.busy_before", 864'(busy), 864'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid.busy_rst", 864'(busy), 864'(0));
    chk("mid.map_rst", map, '0);
    step(); rst = 1'b0; exp_map = '0;
    step();
    chk("mid.busy_after", 864'(busy), 864'(0));
    req_a = 1; pos_a = 8'd1; card_a = 6'd4;
    step(); req_a = 0;
    set_exp(1, 4);
    chk_pulses("mid.idle", 1, 0, 0, 1);
    chk("mid.map", map, exp_map);

    // window behaviour for v_cnt
    v_cnt = 10'd100;
    req_a = 1; pos_a = 8'd2; card_a = 6'd6;
`ifdef MAP_VBLANK_SYNC_EN
    repeat (3) begin
      step();
      chk("win.hold", 864'(ack_a), 864'(0));
    end
    v_cnt = 10'd479;
    step(); chk("win.479", 864'(ack_a), 864'(0));
    v_cnt = 10'd480;
    step(); req_a = 0;
    chk("win.480", 864'(ack_a), 864'(1));
`else
    step(); req_a = 0;
    chk("win.ignored", 864'(ack_a), 864'(1));
`endif
    set_exp(2, 6);
    chk("win.map", map, exp_map);
    v_cnt = 10'd480;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
